// File: rtl/calc_pkg.sv
// Shared calculator definitions: sequencer states, converter states and
// active-low seven-segment patterns ({g,f,e,d,c,b,a}).
package calc_pkg;

  typedef enum logic [2:0] {
    S0_IDLE      = 3'd0,
    S1_OP1       = 3'd1,
    S2_OP1_WR    = 3'd2,
    S3_OP2       = 3'd3,
    S4_OP2_WR    = 3'd4,
    S5_CALCULATE = 3'd5
  } state_t;

  typedef logic [1:0] cv_state_t;
  localparam cv_state_t CV_IDLE   = 2'd0;
  localparam cv_state_t CV_SHIFT  = 2'd1;
  localparam cv_state_t CV_COMMIT = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  function automatic logic [6:0] seg7_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg7_digit = 7'b1000000;
      4'd1:    seg7_digit = 7'b1111001;
      4'd2:    seg7_digit = 7'b0100100;
      4'd3:    seg7_digit = 7'b0110000;
      4'd4:    seg7_digit = 7'b0011001;
      4'd5:    seg7_digit = 7'b0010010;
      4'd6:    seg7_digit = 7'b0000010;
      4'd7:    seg7_digit = 7'b1111000;
      4'd8:    seg7_digit = 7'b0000000;
      4'd9:    seg7_digit = 7'b0010000;
      default: seg7_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/calc_display_bin2bcd.sv
// Sequential double-dabble: one add-3/shift step per cycle, result held in
// bcd from the commit edge until the next commit.
module bin2bcd
  import calc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic                commit,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int IW = $clog2(WIDTH + 1);

  cv_state_t         cv_state;
  logic [4*NDIG-1:0] scratch;
  logic [4*NDIG-1:0] adj;
  logic [WIDTH-1:0]  shreg;
  logic [IW-1:0]     iter;

  assign busy   = (cv_state != CV_IDLE);
  assign commit = (cv_state == CV_COMMIT);

  // Add-3 correction of every BCD nibble that would overflow on the shift
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Converter FSM: accept load only when idle, shift WIDTH times, commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cv_state <= CV_IDLE;
      scratch  <= '0;
      shreg    <= '0;
      iter     <= '0;
      bcd      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (cv_state)
        CV_IDLE: begin
          if (load) begin
            shreg    <= bin;
            scratch  <= '0;
            iter     <= '0;
            cv_state <= CV_SHIFT;
          end
        end
        CV_SHIFT: begin
          {scratch, shreg} <= {adj, shreg} << 1;
          iter             <= iter + 1'b1;
          if (iter == IW'(WIDTH - 1))
            cv_state <= CV_COMMIT;
        end
        CV_COMMIT: begin
          bcd      <= scratch;
          done     <= 1'b1;
          cv_state <= CV_IDLE;
        end
        default: cv_state <= CV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/calc_display.sv
// Signed value presenter: sign/magnitude front end, BCD conversion,
// multiplexed active-low four-digit seven-segment display.
module calc_display
  import calc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int SCAN_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        state,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp_n
);

  localparam int NDIG = DIGITS - 1;
  localparam int CW   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [WIDTH-1:0]  mag;
  logic              accept;
  logic              commit;
  logic              sign_pend;
  logic              disp_sign;
  logic [4*NDIG-1:0] disp_bcd;
  logic [CW-1:0]     scan_cnt;
  logic [IW-1:0]     idx;
  logic [NDIG-1:0]   shown;
  logic              seen;
  logic [6:0]        seg_nx;
  logic [DIGITS-1:0] an_nx;
  logic              dp_nx;

  assign accept = load & ~busy;
  // Two's-complement negate; the most negative input maps to 2^(WIDTH-1) unsigned
  assign mag    = value[WIDTH-1] ? (~value + WIDTH'(1)) : value;

  bin2bcd #(.WIDTH(WIDTH), .NDIG(NDIG)) u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .bin    (mag),
    .busy   (busy),
    .done   (done),
    .commit (commit),
    .bcd    (disp_bcd)
  );

  // Sign travels alongside the conversion and is committed with the digits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sign_pend <= 1'b0;
      disp_sign <= 1'b0;
    end else begin
      if (accept) sign_pend <= value[WIDTH-1];
      if (commit) disp_sign <= sign_pend;
    end
  end

  // Scan timer: hold each digit SCAN_CYCLES clocks, then advance the index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == CW'(SCAN_CYCLES - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Digit decode with leading-zero blanking; digit 0 is always shown
  always_comb begin
    seen  = 1'b0;
    shown = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      seen               = seen | (disp_bcd[4*(NDIG-1-i) +: 4] != 4'd0);
      shown[NDIG-1-i]    = seen | (i == NDIG - 1);
    end
    seg_nx = SEG_BLANK;
    if (idx == IW'(DIGITS - 1)) begin
      seg_nx = disp_sign ? SEG_MINUS : SEG_BLANK;
    end else begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (idx == IW'(i) && shown[i])
          seg_nx = seg7_digit(disp_bcd[4*i +: 4]);
      end
    end
    an_nx = (state == S0_IDLE) ? '1 : ~(DIGITS'(1) << idx);
    dp_nx = ~((idx == '0) && (state == S2_OP1_WR || state == S4_OP2_WR));
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= '1;
      seg  <= SEG_BLANK;
      dp_n <= 1'b1;
    end else begin
      an   <= an_nx;
      seg  <= seg_nx;
      dp_n <= dp_nx;
    end
  end

endmodule
